// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared constants and helpers for the video timing generator.
//   - DEF_* : default timing set (256x240 visible, NES-like borders)
//   - axis_total  : total length of one axis (display + porches + sync)
//   - sync_active : true when pos lies inside [start, start+width)
package video_timing_pkg;

    localparam int unsigned DEF_H_DISPLAY = 256;
    localparam int unsigned DEF_H_FRONT   = 7;
    localparam int unsigned DEF_H_SYNC    = 23;
    localparam int unsigned DEF_H_BACK    = 23;
    localparam int unsigned DEF_V_DISPLAY = 240;
    localparam int unsigned DEF_V_BOTTOM  = 14;
    localparam int unsigned DEF_V_SYNC    = 8;
    localparam int unsigned DEF_V_TOP     = 5;
    localparam int unsigned DEF_CW        = 9;
    localparam int unsigned DEF_FCW       = 8;

    function automatic int unsigned axis_total(input int unsigned display,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return display + front + sync + back;
    endfunction

    function automatic logic sync_active(input int unsigned pos,
                                         input int unsigned start,
                                         input int unsigned width);
        return (pos >= start) && (pos < start + width);
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// video_timing_axis
//   One timing axis (horizontal or vertical): a wrapping position counter
//   with a registered sync output decoded from the next position.
//   Ports:
//     clk    in   clock
//     reset  in   asynchronous active-high reset
//     step   in   advance the position on this clk edge
//     pos    out  [CW-1:0] registered position
//     sync   out  registered sync, at POL level inside the sync window
//     active out  combinational lookahead: next position is in the display
//                 area (the parent registers it alongside pos)
//     wrap   out  combinational: this edge takes pos from MAX back to 0
module video_timing_axis
    import video_timing_pkg::*;
#(
    parameter int unsigned DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned FRONT   = DEF_H_FRONT,
    parameter int unsigned SYNC    = DEF_H_SYNC,
    parameter int unsigned BACK    = DEF_H_BACK,
    parameter bit          POL     = 1'b1,
    parameter int unsigned CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    output logic [CW-1:0] pos,
    output logic          sync,
    output logic          active,
    output logic          wrap
);

    localparam int unsigned TOTAL      = axis_total(DISPLAY, FRONT, SYNC, BACK);
    localparam int unsigned MAX        = TOTAL - 1;
    localparam int unsigned SYNC_START = DISPLAY + FRONT;
    localparam logic [CW-1:0] POS_MAX  = CW'(MAX);

    if (FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_widths
        $error("video_timing_axis: porch and sync widths must be >= 1");
    end

    if (longint'(MAX) >= (longint'(1) << CW)) begin : g_bad_cw
        $error("video_timing_axis: CW too narrow for axis total");
    end

    logic [CW-1:0] pos_next;

    always_comb begin
        wrap     = step && (pos == POS_MAX);
        pos_next = pos;
        if (wrap) begin
            pos_next = '0;
        end else if (step) begin
            pos_next = pos + CW'(1);
        end
        active = 32'(pos_next) < DISPLAY;
    end

    // Decoding from pos_next keeps sync aligned with the registered pos.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos  <= '0;
            sync <= ~POL;
        end else begin
            pos  <= pos_next;
            sync <= sync_active(32'(pos_next), SYNC_START, SYNC) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Parametrised video timing generator: position counters, sync, blanking,
//   line/frame strobes and a frame counter. All outputs are registered and
//   describe the pixel currently on hpos/vpos.
//   Ports:
//     clk          in   clock
//     reset        in   asynchronous active-high reset
//     pix_en       in   pixel clock enable
//     hpos, vpos   out  [CW-1:0] current column / line
//     hsync, vsync out  sync at HSYNC_POL / VSYNC_POL level when active
//     display_on   out  (hpos,vpos) inside the visible area
//     vblank       out  vpos >= V_DISPLAY
//     line_start   out  one-clk pulse when hpos wraps to 0
//     frame_start  out  one-clk pulse when hpos and vpos both wrap to 0
//     frame_count  out  [FCW-1:0] completed frames, wrapping
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_BOTTOM  = DEF_V_BOTTOM,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_TOP     = DEF_V_TOP,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1,
    parameter int unsigned CW        = DEF_CW,
    parameter int unsigned FCW       = DEF_FCW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    output logic [CW-1:0]  hpos,
    output logic [CW-1:0]  vpos,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic           vblank,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count
);

    logic h_wrap;
    logic v_wrap;
    logic h_active;
    logic v_active;
    logic v_step;

    assign v_step = pix_en & h_wrap;

    video_timing_axis #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (HSYNC_POL),
        .CW      (CW)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .step   (pix_en),
        .pos    (hpos),
        .sync   (hsync),
        .active (h_active),
        .wrap   (h_wrap)
    );

    video_timing_axis #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_BOTTOM),
        .SYNC    (V_SYNC),
        .BACK    (V_TOP),
        .POL     (VSYNC_POL),
        .CW      (CW)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .step   (v_step),
        .pos    (vpos),
        .sync   (vsync),
        .active (v_active),
        .wrap   (v_wrap)
    );

    // h_wrap/v_wrap are already gated by pix_en, so the strobes drop to 0
    // on disabled cycles while the decoded outputs simply hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            display_on  <= 1'b1;
            vblank      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            display_on  <= h_active && v_active;
            vblank      <= !v_active;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (v_wrap) begin
                frame_count <= frame_count + FCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
//   Directed bench for video_timing_gen: a default-parameter instance
//   (dut1) and a tiny active-low, FCW=2 instance (dut2, 8x6 total).
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic       rst1, en1;
    logic [8:0] hpos1, vpos1;
    logic       hs1, vs1, disp1, vb1, ls1, fs1;
    logic [7:0] fc1;

    // small instance: H 4+1+2+1=8, V 3+1+1+1=6, active-low syncs
    logic       rst2, en2;
    logic [3:0] hpos2, vpos2;
    logic       hs2, vs2, disp2, vb2, ls2, fs2;
    logic [1:0] fc2;

    int checks = 0;
    int passes = 0;
    int since_rel = 0;

    logic [8:0] m1_h, m1_v;
    logic       m1_ls, m1_fs;
    logic [7:0] m1_fc;
    logic [3:0] m2_h, m2_v;
    logic       m2_ls, m2_fs;
    logic [1:0] m2_fc;

    logic [31:0] got1;
    logic [15:0] got2;
    assign got1 = {hpos1, vpos1, hs1, vs1, disp1, vb1, ls1, fs1, fc1};
    assign got2 = {hpos2, vpos2, hs2, vs2, disp2, vb2, ls2, fs2, fc2};

    localparam logic [31:0] RST1 = {9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    localparam logic [15:0] RST2 = {4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};

    video_timing_gen dut1 (
        .clk         (clk),
        .reset       (rst1),
        .pix_en      (en1),
        .hpos        (hpos1),
        .vpos        (vpos1),
        .hsync       (hs1),
        .vsync       (vs1),
        .display_on  (disp1),
        .vblank      (vb1),
        .line_start  (ls1),
        .frame_start (fs1),
        .frame_count (fc1)
    );

    video_timing_gen #(
        .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_DISPLAY (3), .V_BOTTOM (1), .V_SYNC (1), .V_TOP (1),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0),
        .CW (4), .FCW (2)
    ) dut2 (
        .clk         (clk),
        .reset       (rst2),
        .pix_en      (en2),
        .hpos        (hpos2),
        .vpos        (vpos2),
        .hsync       (hs2),
        .vsync       (vs2),
        .display_on  (disp2),
        .vblank      (vb2),
        .line_start  (ls2),
        .frame_start (fs2),
        .frame_count (fc2)
    );

    task automatic m1_reset();
        m1_h = '0; m1_v = '0; m1_ls = 1'b0; m1_fs = 1'b0; m1_fc = '0;
    endtask

    task automatic m1_tick(input logic en);
        logic hw, vw;
        hw = en && (m1_h == 9'd308);
        vw = hw && (m1_v == 9'd266);
        if (en) m1_h = hw ? 9'd0 : m1_h + 9'd1;
        if (hw) m1_v = vw ? 9'd0 : m1_v + 9'd1;
        m1_ls = hw;
        m1_fs = vw;
        if (vw) m1_fc = m1_fc + 8'd1;
    endtask

    function automatic logic [31:0] exp1();
        logic hs, vs, dp, vb;
        hs = (m1_h >= 9'd263) && (m1_h <= 9'd285);
        vs = (m1_v >= 9'd254) && (m1_v <= 9'd261);
        dp = (m1_h < 9'd256) && (m1_v < 9'd240);
        vb = (m1_v >= 9'd240);
        return {m1_h, m1_v, hs, vs, dp, vb, m1_ls, m1_fs, m1_fc};
    endfunction

    task automatic m2_tick(input logic en);
        logic hw, vw;
        hw = en && (m2_h == 4'd7);
        vw = hw && (m2_v == 4'd5);
        if (en) m2_h = hw ? 4'd0 : m2_h + 4'd1;
        if (hw) m2_v = vw ? 4'd0 : m2_v + 4'd1;
        m2_ls = hw;
        m2_fs = vw;
        if (vw) m2_fc = m2_fc + 2'd1;
    endtask

    function automatic logic [15:0] exp2();
        logic hs, vs, dp, vb;
        hs = !((m2_h >= 4'd5) && (m2_h <= 4'd6));
        vs = !(m2_v == 4'd4);
        dp = (m2_h < 4'd4) && (m2_v < 4'd3);
        vb = (m2_v >= 4'd3);
        return {m2_h, m2_v, hs, vs, dp, vb, m2_ls, m2_fs, m2_fc};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got1 !== RST1) $display("FAIL reset_dut1: got %h expected %h", got1, RST1);
        else passes++;
        checks++;
        if (got2 !== RST2) $display("FAIL reset_dut2: got %h expected %h", got2, RST2);
        else passes++;
        checks++;
        if (hs2 !== 1'b1 || vs2 !== 1'b1)
            $display("FAIL reset_low_pol_syncs: got hsync=%b vsync=%b expected 1 1", hs2, vs2);
        else passes++;
    endtask

    task automatic test_line();
        int bad = 0, c_bad = 0, ls_n = 0, first_ls = 0, second_ls = 0, hs_n = 0, hmax = 0;
        logic [31:0] g_bad = '0, e_bad = '0;
        logic [8:0] h_first = '0;
        rst1 = 1'b0;
        m1_reset();
        since_rel = 0;
        for (int c = 1; c <= 620; c++) begin
            @(posedge clk);
            m1_tick(en1);
            since_rel++;
            #1;
            if (c == 1) h_first = hpos1;
            if (got1 !== exp1()) begin
                if (bad == 0) begin g_bad = got1; e_bad = exp1(); c_bad = c; end
                bad++;
            end
            if (ls1 === 1'b1) begin
                ls_n++;
                if (ls_n == 1) first_ls = c;
                else if (ls_n == 2) second_ls = c;
            end
            if (hs1 === 1'b1) hs_n++;
            if (int'(hpos1) > hmax) hmax = int'(hpos1);
        end
        checks++;
        if (h_first !== 9'd1) $display("FAIL line_first_hpos: got %0d expected 1", h_first);
        else passes++;
        checks++;
        if (bad != 0) $display("FAIL line_bundle: %0d bad cycles, first at %0d got %h expected %h", bad, c_bad, g_bad, e_bad);
        else passes++;
        checks++;
        if (hmax != 308) $display("FAIL line_hmax: got %0d expected 308", hmax);
        else passes++;
        checks++;
        if (ls_n != 2 || first_ls != 309 || second_ls != 618)
            $display("FAIL line_start_timing: got n=%0d at %0d,%0d expected n=2 at 309,618", ls_n, first_ls, second_ls);
        else passes++;
        checks++;
        if (hs_n != 46) $display("FAIL line_hsync_width: got %0d high cycles expected 46", hs_n);
        else passes++;
    endtask

    task automatic test_frame();
        int bad = 0, c_bad = 0, vs_n = 0, vb_n = 0, fs_n = 0, fs_at = 0, vmax = 0;
        logic [31:0] g_bad = '0, e_bad = '0;
        for (int c = 1; c <= 81888; c++) begin
            @(posedge clk);
            m1_tick(en1);
            since_rel++;
            #1;
            if (got1 !== exp1()) begin
                if (bad == 0) begin g_bad = got1; e_bad = exp1(); c_bad = since_rel; end
                bad++;
            end
            if (vs1 === 1'b1) vs_n++;
            if (vb1 === 1'b1) vb_n++;
            if (fs1 === 1'b1) begin fs_n++; fs_at = since_rel; end
            if (int'(vpos1) > vmax) vmax = int'(vpos1);
        end
        checks++;
        if (bad != 0) $display("FAIL frame_bundle: %0d bad cycles, first at %0d got %h expected %h", bad, c_bad, g_bad, e_bad);
        else passes++;
        checks++;
        if (vmax != 266) $display("FAIL frame_vmax: got %0d expected 266", vmax);
        else passes++;
        checks++;
        if (vs_n != 2472) $display("FAIL frame_vsync_width: got %0d expected 2472", vs_n);
        else passes++;
        checks++;
        if (vb_n != 8343) $display("FAIL frame_vblank_cycles: got %0d expected 8343", vb_n);
        else passes++;
        checks++;
        if (fs_n != 1 || fs_at != 82503)
            $display("FAIL frame_start_timing: got n=%0d at %0d expected n=1 at 82503", fs_n, fs_at);
        else passes++;
        checks++;
        if (fc1 !== 8'd1) $display("FAIL frame_count_1: got %0d expected 1", fc1);
        else passes++;
    endtask

    task automatic test_pix_en();
        int bad = 0, c_bad = 0, strobe_bad = 0, ls_n = 0, first_ls = 0, second_ls = 0;
        logic [31:0] g_bad = '0, e_bad = '0;
        logic applied;
        en1 = 1'b1;
        for (int c = 1; c <= 1240; c++) begin
            @(posedge clk);
            applied = en1;
            m1_tick(applied);
            #1;
            if (got1 !== exp1()) begin
                if (bad == 0) begin g_bad = got1; e_bad = exp1(); c_bad = c; end
                bad++;
            end
            if (!applied && (ls1 !== 1'b0 || fs1 !== 1'b0)) strobe_bad++;
            if (ls1 === 1'b1) begin
                ls_n++;
                if (ls_n == 1) first_ls = c;
                else if (ls_n == 2) second_ls = c;
            end
            en1 = ~en1;
        end
        en1 = 1'b1;
        checks++;
        if (bad != 0) $display("FAIL pix_en_bundle: %0d bad cycles, first at %0d got %h expected %h", bad, c_bad, g_bad, e_bad);
        else passes++;
        checks++;
        if (strobe_bad != 0) $display("FAIL pix_en_strobes: got %0d strobes on disabled cycles expected 0", strobe_bad);
        else passes++;
        checks++;
        if (ls_n != 2 || first_ls != 607 || second_ls != 1225)
            $display("FAIL pix_en_line_period: got n=%0d at %0d,%0d expected n=2 at 607,1225", ls_n, first_ls, second_ls);
        else passes++;
    endtask

    task automatic test_async_reset();
        int n = 0;
        en1 = 1'b1;
        while (!(m1_h == 9'd100 && m1_v == 9'd2) && n < 2000) begin
            @(posedge clk);
            m1_tick(en1);
            #1;
            n++;
        end
        checks++;
        if (hpos1 !== 9'd100 || vpos1 !== 9'd2)
            $display("FAIL async_reach: got hpos=%0d vpos=%0d expected 100 2", hpos1, vpos1);
        else passes++;
        #3;
        rst1 = 1'b1;
        #1;
        checks++;
        if (got1 !== RST1) $display("FAIL async_reset_midcycle: got %h expected %h", got1, RST1);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (got1 !== RST1) $display("FAIL async_reset_held: got %h expected %h", got1, RST1);
        else passes++;
        rst1 = 1'b0;
        m1_reset();
        @(posedge clk);
        m1_tick(en1);
        #1;
        checks++;
        if (hpos1 !== 9'd1 || vpos1 !== 9'd0 || ls1 !== 1'b0 || fs1 !== 1'b0)
            $display("FAIL async_release: got hpos=%0d vpos=%0d ls=%b fs=%b expected 1 0 0 0", hpos1, vpos1, ls1, fs1);
        else passes++;
    endtask

    task automatic test_small();
        int bad = 0, c_bad = 0, disp_bad = 0, hs_low = 0, vs_low = 0;
        logic [15:0] g_bad = '0, e_bad = '0;
        logic [1:0] fcs[$];
        logic [9:0] seq = '0;
        rst2 = 1'b0;
        en2 = 1'b1;
        m2_h = '0; m2_v = '0; m2_ls = 1'b0; m2_fs = 1'b0; m2_fc = '0;
        for (int c = 1; c <= 243; c++) begin
            @(posedge clk);
            m2_tick(en2);
            #1;
            if (got2 !== exp2()) begin
                if (bad == 0) begin g_bad = got2; e_bad = exp2(); c_bad = c; end
                bad++;
            end
            if (disp2 !== ((hpos2 < 4'd4) && (vpos2 < 4'd3))) disp_bad++;
            if (hs2 === 1'b0) hs_low++;
            if (vs2 === 1'b0) vs_low++;
            if (fs2 === 1'b1) fcs.push_back(fc2);
        end
        checks++;
        if (bad != 0) $display("FAIL small_bundle: %0d bad cycles, first at %0d got %h expected %h", bad, c_bad, g_bad, e_bad);
        else passes++;
        checks++;
        if (disp_bad != 0) $display("FAIL small_display_on: got %0d bad cycles expected 0", disp_bad);
        else passes++;
        checks++;
        if (hs_low != 60 || vs_low != 40)
            $display("FAIL small_sync_low: got hs_low=%0d vs_low=%0d expected 60 40", hs_low, vs_low);
        else passes++;
        if (fcs.size() == 5) seq = {fcs[0], fcs[1], fcs[2], fcs[3], fcs[4]};
        checks++;
        if (fcs.size() != 5 || seq !== 10'b01_10_11_00_01)
            $display("FAIL small_frame_count_seq: got n=%0d seq=%b expected n=5 seq=0110110001", fcs.size(), seq);
        else passes++;
    endtask

    initial begin
        rst1 = 1'b1; en1 = 1'b1;
        rst2 = 1'b1; en2 = 1'b1;
        m1_reset();
        m2_h = '0; m2_v = '0; m2_ls = 1'b0; m2_fs = 1'b0; m2_fc = '0;
        test_reset();
        test_line();
        test_frame();
        test_pix_en();
        test_async_reset();
        test_small();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
